// File: rtl/uart_tx_frame_packer.sv
// Packs one tracker box result into an 11-byte UART frame (2 header, 8 payload, checksum)
// and feeds it one byte at a time through the transmitter's 1-cycle enable/done handshake.
module uart_tx_frame_packer #(
    parameter logic [7:0]  HDR0    = 8'h55,
    parameter logic [7:0]  HDR1    = 8'hAA,
    parameter logic [7:0]  GAP     = 8'd0,
    parameter logic [17:0] TIMEOUT = 18'd150000
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        frame_start_i,
    input  logic [15:0] box_x_i,
    input  logic [15:0] box_y_i,
    input  logic [15:0] box_w_i,
    input  logic [15:0] box_h_i,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_en_o,
    input  logic        uart_tx_done_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        timeout_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TMO_W  = 18;
    localparam int unsigned BOX_W  = 16;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(10);
    localparam logic [BYTE_W-1:0] DROP_MAX = BYTE_W'(255);

    typedef struct packed {
        logic [BOX_W-1:0] x;
        logic [BOX_W-1:0] y;
        logic [BOX_W-1:0] w;
        logic [BOX_W-1:0] h;
    } box_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t             state;
    box_t               box;
    logic [IDX_W-1:0]   idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [BYTE_W-1:0]  gap_cnt;
    logic [BYTE_W-1:0]  csum_c;

    // Checksum over the latched payload only; headers are excluded.
    always_comb begin
        csum_c = box.x[15:8] + box.x[7:0] + box.y[15:8] + box.y[7:0]
               + box.w[15:8] + box.w[7:0] + box.h[15:8] + box.h[7:0];
    end

    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  i,
        input box_t              b,
        input logic [BYTE_W-1:0] cs
    );
        case (i)
            4'd0:    frame_byte = HDR0;
            4'd1:    frame_byte = HDR1;
            4'd2:    frame_byte = b.x[15:8];
            4'd3:    frame_byte = b.x[7:0];
            4'd4:    frame_byte = b.y[15:8];
            4'd5:    frame_byte = b.y[7:0];
            4'd6:    frame_byte = b.w[15:8];
            4'd7:    frame_byte = b.w[7:0];
            4'd8:    frame_byte = b.h[15:8];
            4'd9:    frame_byte = b.h[7:0];
            default: frame_byte = cs;
        endcase
    endfunction

    // Enable and data are loaded on the transition into SEND so the strobe lines up with that state.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state          <= ST_IDLE;
            box            <= '0;
            idx            <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            uart_tx_data_o <= '0;
            uart_tx_en_o   <= 1'b0;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            timeout_o      <= 1'b0;
            drop_cnt_o     <= '0;
        end else begin
            uart_tx_en_o <= 1'b0;
            frame_done_o <= 1'b0;
            timeout_o    <= 1'b0;

            if (frame_start_i && busy_o && (drop_cnt_o != DROP_MAX)) begin
                drop_cnt_o <= drop_cnt_o + BYTE_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        box            <= '{x: box_x_i, y: box_y_i, w: box_w_i, h: box_h_i};
                        idx            <= '0;
                        uart_tx_en_o   <= 1'b1;
                        uart_tx_data_o <= HDR0;
                        busy_o         <= 1'b1;
                        state          <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (uart_tx_done_i) begin
                        if (idx == LAST_IDX) begin
                            busy_o       <= 1'b0;
                            frame_done_o <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            if (GAP == 8'd0) begin
                                uart_tx_en_o   <= 1'b1;
                                uart_tx_data_o <= frame_byte(idx + IDX_W'(1), box, csum_c);
                                state          <= ST_SEND;
                            end else begin
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end
                    end else if (tmo_cnt == TIMEOUT - TMO_W'(1)) begin
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP - BYTE_W'(1)) begin
                        uart_tx_en_o   <= 1'b1;
                        uart_tx_data_o <= frame_byte(idx, box, csum_c);
                        state          <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + BYTE_W'(1);
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_packer.sv
// Self-checking bench for uart_tx_frame_packer: two instances (GAP=0/TIMEOUT=50 and
// GAP=3/TIMEOUT=400), each answered by a simple transmitter stand-in that pulses done.
module tb_uart_tx_frame_packer;

    localparam int RESP_DLY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, done_a, done_b;
    logic [15:0] bx, by, bw, bh;
    logic [7:0]  data_a, data_b, drop_a, drop_b;
    logic        en_a, en_b, busy_a, busy_b, fd_a, fd_b, to_a, to_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   cd_a     = 0;
    int   cd_b     = 0;
    bit   resp_a   = 1'b1;
    bit   resp_b   = 1'b1;
    logic [7:0] exp_q[$];

    logic [7:0] norm_frame [11] = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    logic [7:0] b2b_frame  [11] = '{8'h55, 8'hAA, 8'hFF, 8'hFF, 8'h00, 8'h00,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame_packer #(.GAP(8'd0), .TIMEOUT(18'd50)) dut_a (
        .iclk(clk), .irst(rst), .frame_start_i(start_a),
        .box_x_i(bx), .box_y_i(by), .box_w_i(bw), .box_h_i(bh),
        .uart_tx_data_o(data_a), .uart_tx_en_o(en_a), .uart_tx_done_i(done_a),
        .busy_o(busy_a), .frame_done_o(fd_a), .timeout_o(to_a), .drop_cnt_o(drop_a)
    );

    uart_tx_frame_packer #(.GAP(8'd3), .TIMEOUT(18'd400)) dut_b (
        .iclk(clk), .irst(rst), .frame_start_i(start_b),
        .box_x_i(bx), .box_y_i(by), .box_w_i(bw), .box_h_i(bh),
        .uart_tx_data_o(data_b), .uart_tx_en_o(en_b), .uart_tx_done_i(done_b),
        .busy_o(busy_b), .frame_done_o(fd_b), .timeout_o(to_b), .drop_cnt_o(drop_b)
    );

    // Advance to the next falling edge and play the transmitter: done RESP_DLY cycles after enable.
    task automatic step();
        @(negedge clk);
        done_a = 1'b0;
        done_b = 1'b0;
        if (cd_a > 0) begin
            cd_a--;
            if (cd_a == 0 && resp_a) done_a = 1'b1;
        end
        if (en_a) cd_a = RESP_DLY;
        if (cd_b > 0) begin
            cd_b--;
            if (cd_b == 0 && resp_b) done_b = 1'b1;
        end
        if (en_b) cd_b = RESP_DLY;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        bx = '0; by = '0; bw = '0; bh = '0;
        step(); step();
        checks++;
        if ({en_a, busy_a, fd_a, to_a} !== 4'b0000)
            $display("FAIL reset_ctrl_a: got %b expected 0000", {en_a, busy_a, fd_a, to_a});
        checks++;
        if (data_a !== 8'h00) $display("FAIL reset_data_a: got %h expected 00", data_a);
        checks++;
        if (drop_a !== 8'h00) $display("FAIL reset_drop_a: got %0d expected 0", drop_a);
        checks++;
        if ({en_b, busy_b, fd_b, to_b, data_b, drop_b} !== 20'h0)
            $display("FAIL reset_b: got %h expected 0", {en_b, busy_b, fd_b, to_b, data_b, drop_b});
        failures += (({en_a, busy_a, fd_a, to_a} !== 4'b0000) ? 1 : 0)
                  + ((data_a !== 8'h00) ? 1 : 0) + ((drop_a !== 8'h00) ? 1 : 0)
                  + (({en_b, busy_b, fd_b, to_b, data_b, drop_b} !== 20'h0) ? 1 : 0);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int exp_en = 0, n_en = 0, n_fd = 0, hold_bad = 0, extra = 0;
        logic [7:0] last = 8'h00, want;
        exp_q.delete();
        foreach (norm_frame[i]) exp_q.push_back(norm_frame[i]);
        step();
        bx = 16'h0102; by = 16'h0304; bw = 16'h0506; bh = 16'h0708;
        start_a = 1'b1; exp_en = cyc + 1;
        for (int i = 0; i < 200 && n_fd == 0; i++) begin
            step();
            start_a = 1'b0;
            if (en_a) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (data_a !== want) begin
                    failures++; $display("FAIL normal_byte%0d: got %h expected %h", n_en, data_a, want);
                end
                checks++;
                if (cyc !== exp_en) begin
                    failures++; $display("FAIL normal_en_time%0d: got cycle %0d expected %0d", n_en, cyc, exp_en);
                end
                last = data_a; n_en++;
            end else if (busy_a && data_a !== last) hold_bad++;
            if (done_a) exp_en = cyc + 1;
            if (fd_a) begin
                n_fd++;
                checks++;
                if (busy_a !== 1'b0 || cyc !== exp_en) begin
                    failures++; $display("FAIL normal_done: busy %b cycle %0d expected busy 0 cycle %0d", busy_a, cyc, exp_en);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (en_a || fd_a || busy_a) extra++;
        end
        checks++;
        if (n_en != 11) begin failures++; $display("FAIL normal_count: got %0d enables expected 11", n_en); end
        checks++;
        if (n_fd != 1 || extra != 0) begin
            failures++; $display("FAIL normal_fd: got %0d done pulses %0d stray cycles expected 1 and 0", n_fd, extra);
        end
        checks++;
        if (hold_bad != 0) begin failures++; $display("FAIL normal_hold: got %0d data changes expected 0", hold_bad); end
    endtask

    task automatic test_gap();
        int exp_en = 0, n_en = 0, n_fd = 0;
        logic [7:0] want;
        exp_q.delete();
        foreach (norm_frame[i]) exp_q.push_back(norm_frame[i]);
        step();
        bx = 16'h0102; by = 16'h0304; bw = 16'h0506; bh = 16'h0708;
        start_b = 1'b1; exp_en = cyc + 1;
        for (int i = 0; i < 300 && n_fd == 0; i++) begin
            step();
            start_b = 1'b0;
            if (en_b) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (data_b !== want) begin
                    failures++; $display("FAIL gap_byte%0d: got %h expected %h", n_en, data_b, want);
                end
                checks++;
                if (cyc !== exp_en) begin
                    failures++; $display("FAIL gap_en_time%0d: got cycle %0d expected %0d", n_en, cyc, exp_en);
                end
                n_en++;
            end
            if (done_b) exp_en = cyc + 4;
            if (fd_b) n_fd++;
        end
        checks++;
        if (n_en != 11 || n_fd != 1) begin
            failures++; $display("FAIL gap_count: got %0d enables %0d done expected 11 and 1", n_en, n_fd);
        end
    endtask

    task automatic test_drops();
        int n_en = 0, n_fd = 0;
        logic [7:0] want;
        exp_q.delete();
        foreach (norm_frame[i]) exp_q.push_back(norm_frame[i]);
        step();
        bx = 16'h0102; by = 16'h0304; bw = 16'h0506; bh = 16'h0708;
        start_a = 1'b1;
        for (int i = 0; i < 200 && n_fd == 0; i++) begin
            step();
            bx = 16'hDEAD; by = 16'hBEEF; bw = 16'hCAFE; bh = 16'hF00D;
            start_a = (i == 5 || i == 15 || i == 25);
            if (en_a) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (data_a !== want) begin
                    failures++; $display("FAIL drops_byte%0d: got %h expected %h", n_en, data_a, want);
                end
                n_en++;
            end
            if (fd_a) n_fd++;
        end
        start_a = 1'b0;
        step();
        checks++;
        if (n_en != 11) begin failures++; $display("FAIL drops_count: got %0d enables expected 11", n_en); end
        checks++;
        if (drop_a !== 8'd3) begin failures++; $display("FAIL drops_cnt: got %0d expected 3", drop_a); end
    endtask

    task automatic test_timeout();
        int n_en = 0, n_fd = 0, en_cyc = -1000, to_cyc = -1, late_en = 0;
        resp_a = 1'b0;
        step();
        bx = 16'h1111; by = 16'h2222; bw = 16'h3333; bh = 16'h4444;
        start_a = 1'b1;
        for (int i = 0; i < 120 && to_cyc < 0; i++) begin
            step();
            start_a = 1'b0;
            if (en_a) begin
                n_en++; en_cyc = cyc;
                checks++;
                if (data_a !== 8'h55) begin failures++; $display("FAIL timeout_byte: got %h expected 55", data_a); end
            end
            if (fd_a) n_fd++;
            if (to_a) begin
                to_cyc = cyc;
                checks++;
                if (busy_a !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy_a); end
            end
        end
        checks++;
        if (to_cyc !== en_cyc + 51) begin
            failures++; $display("FAIL timeout_time: got cycle %0d expected %0d", to_cyc, en_cyc + 51);
        end
        step();
        done_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (en_a || busy_a) late_en++;
            if (fd_a) n_fd++;
        end
        checks++;
        if (n_en != 1 || n_fd != 0 || late_en != 0) begin
            failures++; $display("FAIL timeout_quiet: got %0d enables %0d done %0d late activity expected 1 0 0", n_en, n_fd, late_en);
        end
        resp_a = 1'b1;
    endtask

    task automatic test_saturate();
        int seen_to = 0;
        resp_b = 1'b0;
        step();
        start_b = 1'b1;
        for (int i = 0; i < 301; i++) step();
        start_b = 1'b0;
        step();
        checks++;
        if (drop_b !== 8'd255) begin failures++; $display("FAIL saturate_cnt: got %0d expected 255", drop_b); end
        for (int i = 0; i < 500 && seen_to == 0; i++) begin
            step();
            if (to_b) seen_to = 1;
        end
        checks++;
        if (seen_to != 1 || drop_b !== 8'd255) begin
            failures++; $display("FAIL saturate_after: got timeout %0d drop %0d expected 1 and 255", seen_to, drop_b);
        end
        resp_b = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n_en = 0, act = 0;
        step();
        bx = 16'h0102; by = 16'h0304; bw = 16'h0506; bh = 16'h0708;
        start_a = 1'b1;
        for (int i = 0; i < 200 && n_en < 6; i++) begin
            step();
            start_a = 1'b0;
            if (en_a) n_en++;
        end
        step();
        checks++;
        if (busy_a !== 1'b1 || n_en != 6) begin
            failures++; $display("FAIL rstmid_pre: got busy %b enables %0d expected 1 and 6", busy_a, n_en);
        end
        rst = 1'b1; resp_a = 1'b0; cd_a = 0;
        step();
        rst = 1'b0;
        checks++;
        if ({en_a, busy_a, fd_a, to_a, data_a, drop_a} !== 20'h0) begin
            failures++; $display("FAIL rstmid_outputs: got %h expected 0", {en_a, busy_a, fd_a, to_a, data_a, drop_a});
        end
        checks++;
        if (drop_b !== 8'd0) begin failures++; $display("FAIL rstmid_drop_b: got %0d expected 0", drop_b); end
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 9) done_a = 1'b1;
            if (en_a || busy_a || fd_a || to_a) act++;
        end
        checks++;
        if (act != 0) begin failures++; $display("FAIL rstmid_late_done: got %0d active cycles expected 0", act); end
        resp_a = 1'b1;
    endtask

    task automatic test_back_to_back();
        int exp_en = 0, n_en = 0, n_fd = 0;
        logic [7:0] want;
        exp_q.delete();
        foreach (norm_frame[i]) exp_q.push_back(norm_frame[i]);
        foreach (b2b_frame[i]) exp_q.push_back(b2b_frame[i]);
        step();
        bx = 16'h0102; by = 16'h0304; bw = 16'h0506; bh = 16'h0708;
        start_a = 1'b1; exp_en = cyc + 1;
        for (int i = 0; i < 400 && n_fd < 2; i++) begin
            step();
            start_a = 1'b0;
            if (en_a) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (data_a !== want || cyc !== exp_en) begin
                    failures++;
                    $display("FAIL b2b_byte%0d: got %h at cycle %0d expected %h at %0d", n_en, data_a, cyc, want, exp_en);
                end
                n_en++;
            end
            if (done_a) exp_en = cyc + 1;
            if (fd_a) begin
                n_fd++;
                if (n_fd == 1) begin
                    bx = 16'hFFFF; by = 16'h0000; bw = 16'h0000; bh = 16'h0000;
                    start_a = 1'b1; exp_en = cyc + 1;
                end
            end
        end
        step();
        checks++;
        if (n_en != 22 || n_fd != 2) begin
            failures++; $display("FAIL b2b_count: got %0d enables %0d done expected 22 and 2", n_en, n_fd);
        end
        checks++;
        if (drop_a !== 8'd0) begin failures++; $display("FAIL b2b_drop: got %0d expected 0", drop_a); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gap();
        test_drops();
        test_timeout();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_packer.md
Name: uart_tx_frame_packer

Overview:
- Upstream feeder for the UART byte transmitter.
- Captures one tracker result (box x, y, w, h; 16 bits each) on a start pulse and packs it into an 11-byte frame: header 0x55 0xAA, 8 payload bytes MSB-first, then 1 checksum byte.
- Issues bytes one at a time using the transmitter's 1-cycle enable and 1-cycle done handshake.
- Guards the handshake with a timeout and counts requests dropped while busy.

Parameters:
- HDR0, 8'h55, first header byte
- HDR1, 8'hAA, second header byte
- GAP, 8'd0, idle cycles inserted after each byte's done before the next enable
- TIMEOUT, 18'd150000, max cycles to wait for uart_tx_done_i per byte (> 10 bit periods at 9600 bps / 100 MHz)

Ports:
- iclk  in  1  system clock, 100 MHz
- irst  in  1  synchronous active-high reset
- frame_start_i  in  1  1-cycle request to send one frame
- box_x_i  in  16  box x, sampled on an accepted start
- box_y_i  in  16  box y
- box_w_i  in  16  box width
- box_h_i  in  16  box height
- uart_tx_data_o  out  8  byte to transmitter
- uart_tx_en_o  out  1  1-cycle send strobe to transmitter
- uart_tx_done_i  in  1  1-cycle byte-complete pulse from transmitter
- busy_o  out  1  frame in progress
- frame_done_o  out  1  1-cycle pulse after the checksum byte completes
- timeout_o  out  1  1-cycle pulse on a handshake timeout
- drop_cnt_o  out  8  saturating count of rejected starts

Behaviour:
- Interface: one clock iclk; reset irst is synchronous, active-high.
- Reset: state IDLE, all outputs 0, drop_cnt_o 0, byte index 0, timeout counter 0.
- Reset mid-frame aborts immediately: uart_tx_en_o low from the next cycle; no frame_done_o or timeout_o pulse.
- Payload byte order: x[15:8], x[7:0], y[15:8], y[7:0], w[15:8], w[7:0], h[15:8], h[7:0].
- Checksum: 8-bit sum of the 8 payload bytes, mod 256. Headers are excluded.
- FSM states: IDLE, SEND, WAIT, GAP.
- IDLE: busy_o=0. If frame_start_i is high, latch all four box inputs, set index=0, go to SEND. Start-to-first-enable latency is 1 cycle.
- SEND: uart_tx_en_o=1 for exactly this cycle. uart_tx_data_o = byte[index]. Clear the timeout counter, go to WAIT.
- uart_tx_data_o holds its value until the next SEND.
- WAIT: increment the timeout counter each cycle.
  - If uart_tx_done_i is high and index<10: index++, go to GAP (or directly to SEND if GAP=0).
  - If uart_tx_done_i is high and index==10: go to IDLE, frame_done_o=1 in the next cycle.
  - If the counter reaches TIMEOUT-1 without done: go to IDLE, timeout_o=1 in the next cycle. The frame is abandoned and there is no frame_done_o.
- GAP: count GAP cycles, then go to SEND. Next enable is issued exactly GAP+1 cycles after the done cycle.
- busy_o=1 in SEND, WAIT and GAP.
- A done pulse in IDLE, SEND or GAP is ignored, including a late done after an abort or reset.
- frame_start_i while busy_o=1: dropped, and drop_cnt_o increments, saturating at 255.
- frame_start_i in the same cycle frame_done_o pulses: state is already IDLE, so the start is accepted, giving back-to-back frames.
- Only irst clears drop_cnt_o.
- Box inputs change freely after acceptance. Payload reflects the values at the accepted start cycle.

Test Plan:
- Normal frame (downstream = transmitter with small baud divider), x=16'h0102, y=16'h0304, w=16'h0506, h=16'h0708, start pulse:
  - 11 enables carrying 55 AA 01 02 03 04 05 06 07 08 24.
  - First enable 1 cycle after start; each subsequent enable 1 cycle after the previous done.
  - One frame_done_o pulse; busy_o drops with it.
- GAP=3: each enable occurs exactly 4 cycles after the preceding done. Byte sequence is unchanged.
- Start pulses while busy:
  - 3 extra starts mid-frame give drop_cnt_o=3, and the frame content is unaffected.
  - 300 starts in one busy window give drop_cnt_o=255.
- Timeout, TIMEOUT=50, done never returned:
  - Single enable (0x55), then timeout_o pulse 50 cycles after the WAIT entry.
  - busy_o=0, no frame_done_o; a late done pulse afterwards produces no enable.
- Reset mid-frame (irst during byte 5 WAIT):
  - Outputs all 0 the next cycle and drop_cnt_o=0.
  - A done arriving 10 cycles later is ignored.
  - A new start then sends a full correct frame.
- Back-to-back: a start asserted in the frame_done_o cycle with x=16'hFFFF, y=w=h=0 is accepted (no drop). Second frame is 55 AA FF FF 00 00 00 00 00 00 FE.
